// File: rtl/pair_stream_gen_if.sv
// Command and stimulus bundle between pair_stream_gen and whatever drives or observes it.
interface pair_stream_gen_if #(
    parameter int unsigned LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [1:0]       cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             w1;
    logic             w2;
    logic             w_valid;
    logic             done;
    logic             busy;
    logic             exp_z;

    // Generator side: takes commands, drives the stream.
    modport master (
        input  cmd_valid, cmd_mode, cmd_data, cmd_len,
        output cmd_ready, w1, w2, w_valid, done, busy, exp_z
    );

    // Commanding side: offers commands, observes the stream.
    modport slave (
        output cmd_valid, cmd_mode, cmd_data, cmd_len,
        input  cmd_ready, w1, w2, w_valid, done, busy, exp_z
    );
endinterface

// File: rtl/pair_stream_gen.sv
// Registered (w1,w2) stimulus generator for pair-compare detectors.
// Define PAIR_GEN_EXPZ_EN to include the run-length reference model driving exp_z.
module pair_stream_gen #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned RUN_LEN = 4,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input logic               clk,
    input logic               rst,
    pair_stream_gen_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {MODE_EQ, MODE_NEQ, MODE_CONST, MODE_RAND} mode_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    mode_t            mode_q, mode_d;
    logic [1:0]       data_q, data_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             ready_q, ready_d;
    logic             w1_q, w1_d;
    logic             w2_q, w2_d;
    logic             wv_q, wv_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept_c;
    logic             beat_c;
    mode_t            beat_mode_c;
    logic [1:0]       beat_data_c;
    logic             beat_w1_c;
    logic             beat_w2_c;
    logic             lfsr_fb_c;

    // ready_q is only high in IDLE or on the final beat, so accept_c implies a legal start point.
    assign accept_c  = bus.cmd_valid && ready_q;
    assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        data_d      = data_q;
        lfsr_d      = lfsr_q;
        done_d      = 1'b0;
        beat_c      = 1'b0;
        beat_mode_c = mode_q;
        beat_data_c = data_q;
        beat_w1_c   = 1'b0;
        beat_w2_c   = 1'b0;

        if (accept_c) begin
            if (bus.cmd_len == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d     = RUN;
                rem_d       = bus.cmd_len;
                mode_d      = mode_t'(bus.cmd_mode);
                data_d      = bus.cmd_data;
                beat_c      = 1'b1;
                beat_mode_c = mode_t'(bus.cmd_mode);
                beat_data_c = bus.cmd_data;
            end
        end else if (state_q == RUN) begin
            if (rem_q == LEN_W'(1)) begin
                state_d = IDLE;
            end else begin
                rem_d  = rem_q - LEN_W'(1);
                beat_c = 1'b1;
            end
        end

        case (beat_mode_c)
            MODE_EQ:    begin beat_w1_c = lfsr_q[0];  beat_w2_c = lfsr_q[0]; end
            MODE_NEQ:   begin beat_w1_c = ~lfsr_q[0]; beat_w2_c = lfsr_q[0]; end
            MODE_CONST: begin beat_w1_c = beat_data_c[1]; beat_w2_c = beat_data_c[0]; end
            default:    begin beat_w1_c = lfsr_q[0];  beat_w2_c = lfsr_q[7]; end
        endcase

        if (beat_c) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb_c};
            if (rem_d == LEN_W'(1)) done_d = 1'b1;
        end

        w1_d    = beat_c & beat_w1_c;
        w2_d    = beat_c & beat_w2_c;
        wv_d    = beat_c;
        busy_d  = (state_d == RUN);
        ready_d = (state_d == IDLE) || (rem_d == LEN_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_EQ;
            data_q  <= '0;
            lfsr_q  <= SEED;
            ready_q <= 1'b1;
            w1_q    <= 1'b0;
            w2_q    <= 1'b0;
            wv_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            wv_q    <= wv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.w1        = w1_q;
    assign bus.w2        = w2_q;
    assign bus.w_valid   = wv_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

`ifdef PAIR_GEN_EXPZ_EN
    localparam int unsigned CNT_W = $clog2(RUN_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_z_q, exp_z_d;

    // Reference model watches the emitted beats; idle cycles hold its state.
    always_comb begin
        cnt_d   = cnt_q;
        exp_z_d = exp_z_q;
        if (wv_q) begin
            if (w1_q != w2_q)                   cnt_d = '0;
            else if (cnt_q != CNT_W'(RUN_LEN))  cnt_d = cnt_q + CNT_W'(1);
            exp_z_d = (cnt_d == CNT_W'(RUN_LEN));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            exp_z_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            exp_z_q <= exp_z_d;
        end
    end

    assign bus.exp_z = exp_z_q;
`else
    assign bus.exp_z = 1'b0;
`endif
endmodule

// File: doc/pair_stream_gen.md
# pair_stream_gen

Stimulus generator for the two-input pair-compare FSMs (w1/w2 → z). It is the driving end of that interface. It accepts run commands over a valid/ready handshake and emits a registered (w1, w2) stream of the requested pattern and length. Optionally it also produces the expected detector output z from a reference model, so a bench or on-chip self-test can compare it against the detector under test.

## Interface
- LEN_W, 8: width of cmd_len; a run is 0 to 2^LEN_W−1 beats.
- RUN_LEN, 4: consecutive-equal beats the reference model needs to assert exp_z (2..15).
- SEED, 8'hA5: LFSR reset value; must be nonzero.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  generator can take a command.
- cmd_mode  in  2  0 EQ, 1 NEQ, 2 CONST, 3 RAND.
- cmd_data  in  2  {w1,w2} value for CONST mode; ignored otherwise.
- cmd_len  in  LEN_W  number of beats.
- w1, w2  out  1 each  stimulus; both 0 when w_valid=0.
- w_valid  out  1  w1/w2 carry a beat this cycle.
- done  out  1  one-cycle pulse marking command completion.
- busy  out  1  FSM in RUN.
- exp_z  out  1  model output; present only with the macro, tied 0 otherwise.

## Operation
- FSM states: IDLE and RUN.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready with cmd_len≥1, latch mode/data/len, load remaining=cmd_len, go to RUN.
  - Zero-length command (cmd_len=0): accepted, stays IDLE, emits no beats, pulses done in the next cycle.
- RUN: one beat per cycle. remaining decrements per beat.
  - On the beat with remaining=1, done=1 with that beat and cmd_ready=1.
  - A command accepted on that edge starts the next beat with no bubble. Otherwise go to IDLE.
- Beat values:
  - EQ: w1=w2=L.
  - NEQ: w2=L, w1=~L.
  - CONST: {w1,w2}=cmd_data.
  - RAND: w1=L, w2=L'.
  - L and L' are LFSR bits [0] and [7].
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shift-left, feedback into bit 0.
  - Advances only on cycles that emit a beat.
  - Never reset except by rst, so consecutive commands continue the sequence.
- cmd_ready=0 in RUN except on the final beat. cmd_* are ignored when ready=0.
- No abort. A command always completes.

## Timing
- Reset values: cmd_ready=1, w_valid=0, w1=w2=0, done=0, busy=0, exp_z=0, LFSR=SEED, model count=0, FSM=IDLE.
- Latency:
  - A command accepted at edge k gives its first beat valid in the cycle after edge k.
  - Its last beat is at cycle k+cmd_len. done coincides with the last beat.
- Back-to-back commands give a continuous w_valid with no gap.
- Reset asserted mid-run: outputs go to reset values immediately. The in-flight command is dropped, with no done.
- All outputs are registered. No combinational path from cmd_* to w1/w2/w_valid; only cmd_ready depends on state.

## Configuration
- PAIR_GEN_EXPZ_EN defined: include the reference model.
  - Saturating counter cnt (0..RUN_LEN).
  - On a beat with w1==w2: cnt=min(cnt+1,RUN_LEN). On a beat with w1≠w2: cnt=0. Non-beat cycles hold cnt.
  - exp_z is registered: exp_z=1 in the cycle after a beat leaves cnt=RUN_LEN, else 0 on any beat update. It holds across non-beat cycles.
- Undefined: counter is absent, exp_z is constant 0, port is kept.

## Test plan
- Reset then idle: no commands for 10 cycles → cmd_ready=1, w_valid=0, w1=w2=0, done never pulses.
- CONST, data=2'b10, len=3, accepted at edge k → w_valid=1 with w1=1,w2=0 for the 3 cycles after edge k, done on the 3rd, busy=1 during the run, then IDLE.
- Back-to-back: EQ len=5 then NEQ len=4 offered continuously → 9 contiguous beats. The first 5 have w1==w2 and the last 4 have w1≠w2. cmd_ready=1 only on beat 5 and beat 9.
- cmd_len=0 → no beat, done=1 exactly one cycle after acceptance, cmd_ready stays 1.
- With PAIR_GEN_EXPZ_EN, RUN_LEN=4: CONST 2'b11 len=6 then CONST 2'b01 len=1 → exp_z rises one cycle after the 4th beat, stays 1 through beat 6, and drops one cycle after the 2'b01 beat.
- Reset asserted in the middle of a RAND len=20 run → all outputs at reset values immediately. After release, LFSR restarts from SEED and a repeated RAND command reproduces the original first-beat sequence.
